// File: rtl/booth_mul_pipe.sv
// booth_mul_pipe: radix-4 Booth WIDTHxWIDTH -> 2*WIDTH multiplier, signed or
// unsigned per transaction, four elastic pipeline stages with valid/ready on
// both sides, a sideband tag, synchronous flush and asynchronous reset.
module booth_mul_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);
    localparam int EXT  = WIDTH + 2;
    localparam int PW   = 2 * WIDTH;
    localparam int NDIG = WIDTH / 2 + 1;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_badWidth
            $error("booth_mul_pipe: WIDTH must be even and >= 4");
        end
    endgenerate

    // Stage registers
    logic               r_s1Valid, r_s2Valid, r_s3Valid, r_s4Valid;
    logic [WIDTH-1:0]   r_s1A, r_s1B;
    logic               r_s1Signed;
    logic [TAG_W-1:0]   r_s1Tag, r_s2Tag, r_s3Tag, r_s4Tag;
    logic [PW-1:0]      r_s2Pp [NDIG];
    logic [PW-1:0]      r_s2Corr;
    logic [PW-1:0]      r_s3Sum, r_s3Carry;
    logic [PW-1:0]      r_s4Result;

    // Handshake and datapath wires
    logic               w_s1Hold, w_s2Hold, w_s3Hold, w_s4Hold;
    logic               w_s1Load, w_s2Load, w_s3Load, w_s4Load;
    logic [EXT-1:0]     w_aExt, w_bExt;
    logic [EXT:0]       w_bRec;
    logic [PW-1:0]      w_aWide;
    logic [2:0]         w_digit;
    logic [PW-1:0]      w_mag;
    logic               w_neg;
    logic [PW-1:0]      w_pp [NDIG];
    logic [PW-1:0]      w_corr;
    logic [PW-1:0]      w_sum, w_carry, w_sumNext;

    // A stage holds only when it has a token and everything downstream is stuck,
    // so empty stages always absorb work and bubbles collapse.
    always_comb begin
        w_s4Hold = r_s4Valid & ~out_ready;
        w_s3Hold = r_s3Valid & w_s4Hold;
        w_s2Hold = r_s2Valid & w_s3Hold;
        w_s1Hold = r_s1Valid & w_s2Hold;
        in_ready = ~w_s1Hold & ~flush;
        w_s1Load = in_valid & in_ready;
        w_s2Load = r_s1Valid & ~w_s2Hold & ~flush;
        w_s3Load = r_s2Valid & ~w_s3Hold & ~flush;
        w_s4Load = r_s3Valid & ~w_s4Hold & ~flush;
    end

    assign out_valid  = r_s4Valid;
    assign out_result = r_s4Result;
    assign out_tag    = r_s4Tag;
    assign busy       = r_s1Valid | r_s2Valid | r_s3Valid | r_s4Valid;

    // Stage 1 captures the raw operands, mode and tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_s1A      <= '0;
            r_s1B      <= '0;
            r_s1Signed <= 1'b0;
            r_s1Tag    <= '0;
        end else begin
            if (flush)
                r_s1Valid <= 1'b0;
            else if (!w_s1Hold)
                r_s1Valid <= w_s1Load;
            if (w_s1Load) begin
                r_s1A      <= in_a;
                r_s1B      <= in_b;
                r_s1Signed <= in_signed;
                r_s1Tag    <= in_tag;
            end
        end
    end

    // Booth recoding: each digit of {B_ext,0} selects 0, +-A or +-2A; negative
    // rows are inverted and the +1 goes into a shared correction row.
    always_comb begin
        w_aExt  = {{2{r_s1Signed & r_s1A[WIDTH-1]}}, r_s1A};
        w_bExt  = {{2{r_s1Signed & r_s1B[WIDTH-1]}}, r_s1B};
        w_bRec  = {w_bExt, 1'b0};
        w_aWide = {{(PW-EXT){w_aExt[EXT-1]}}, w_aExt};
        w_corr  = '0;
        w_digit = '0;
        w_mag   = '0;
        w_neg   = 1'b0;
        for (int j = 0; j < NDIG; j++) begin
            w_digit = w_bRec[2*j +: 3];
            case (w_digit)
                3'b001, 3'b010: begin w_mag = w_aWide;      w_neg = 1'b0; end
                3'b011:         begin w_mag = w_aWide << 1; w_neg = 1'b0; end
                3'b100:         begin w_mag = w_aWide << 1; w_neg = 1'b1; end
                3'b101, 3'b110: begin w_mag = w_aWide;      w_neg = 1'b1; end
                default:        begin w_mag = '0;           w_neg = 1'b0; end
            endcase
            w_pp[j]     = (w_neg ? ~w_mag : w_mag) << (2*j);
            w_corr[2*j] = w_neg;
        end
    end

    // Stage 2 stores the shifted partial products and the correction row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2Corr  <= '0;
            r_s2Tag   <= '0;
            for (int j = 0; j < NDIG; j++) r_s2Pp[j] <= '0;
        end else begin
            if (flush)
                r_s2Valid <= 1'b0;
            else if (!w_s2Hold)
                r_s2Valid <= r_s1Valid;
            if (w_s2Load) begin
                r_s2Corr <= w_corr;
                r_s2Tag  <= r_s1Tag;
                for (int j = 0; j < NDIG; j++) r_s2Pp[j] <= w_pp[j];
            end
        end
    end

    // Chain of 3:2 compressors folds all rows into a sum/carry pair; everything
    // is modulo 2^(2*WIDTH) so carries out of the top are simply dropped.
    always_comb begin
        w_sum     = r_s2Corr;
        w_carry   = '0;
        w_sumNext = '0;
        for (int j = 0; j < NDIG; j++) begin
            w_sumNext = w_sum ^ w_carry ^ r_s2Pp[j];
            w_carry   = ((w_sum & w_carry) | (w_sum & r_s2Pp[j]) | (w_carry & r_s2Pp[j])) << 1;
            w_sum     = w_sumNext;
        end
    end

    // Stage 3 stores the carry-save pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3Valid <= 1'b0;
            r_s3Sum   <= '0;
            r_s3Carry <= '0;
            r_s3Tag   <= '0;
        end else begin
            if (flush)
                r_s3Valid <= 1'b0;
            else if (!w_s3Hold)
                r_s3Valid <= r_s2Valid;
            if (w_s3Load) begin
                r_s3Sum   <= w_sum;
                r_s3Carry <= w_carry;
                r_s3Tag   <= r_s2Tag;
            end
        end
    end

    // Stage 4 resolves the carry-save pair and drives the output port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s4Valid  <= 1'b0;
            r_s4Result <= '0;
            r_s4Tag    <= '0;
        end else begin
            if (flush)
                r_s4Valid <= 1'b0;
            else if (!w_s4Hold)
                r_s4Valid <= r_s3Valid;
            if (w_s4Load) begin
                r_s4Result <= r_s3Sum + r_s3Carry;
                r_s4Tag    <= r_s3Tag;
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_pipe.sv
// tb_booth_mul_pipe: directed vector table plus handshake, flush and reset
// sequences for booth_mul_pipe at WIDTH=32, with a scoreboard on the output.
`timescale 1ns/1ps
module tb_booth_mul_pipe;
    localparam int W  = 32;
    localparam int TW = 4;
    localparam int NV = 10;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] exp;
        string          name;
    } vec_t;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic [TW-1:0]  tag;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst, flush, inValid, inReady, inSigned, outValid, outReady, busy;
    logic [W-1:0]   inA, inB;
    logic [TW-1:0]  inTag, outTag;
    logic [2*W-1:0] outResult;

    int checks = 0;
    int errors = 0;

    exp_t expQ[$];
    exp_t monExp;
    int   acceptCount = 0;
    int   consumeCount = 0;
    int   cycleNo = 0;
    int   firstAcceptCycle = -1;
    int   firstOutCycle = -1;
    int   lastOutCycle = -1;
    logic prevHeld = 1'b0;
    logic [2*W-1:0] prevResult;
    logic [TW-1:0]  prevTag;

    logic [W-1:0]   curA, curB;
    logic           curSigned;
    logic [TW-1:0]  curTag;
    logic [TW-1:0]  tagCounter = '0;
    logic           smpReady, smpValid;
    logic [2*W-1:0] smpResult;
    logic [TW-1:0]  smpTag;

    vec_t vecs[NV];

    booth_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_a       (inA),
        .in_b       (inB),
        .in_signed  (inSigned),
        .in_tag     (inTag),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_result (outResult),
        .out_tag    (outTag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo++;

    // Reference product computed with plain wide arithmetic
    function automatic logic [2*W-1:0] modelMul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic signed [2*W-1:0] sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    task automatic checkOutput(input string name, input logic [2*W-1:0] actual, input logic [2*W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bounded wait expired", name);
    endtask

    // Scoreboard: every accepted operand pair must come out once, in order,
    // and a held result must not change until it is taken.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            prevHeld = 1'b0;
        end else begin
            if (prevHeld) begin
                checkOutput("holdValid", 64'(outValid), 64'd1);
                checkOutput("holdResult", outResult, prevResult);
                checkOutput("holdTag", 64'(outTag), 64'(prevTag));
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedOutput: got tag %0d expected no output", outTag);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("scoreResult", outResult, monExp.res);
                    checkOutput("scoreTag", 64'(outTag), 64'(monExp.tag));
                end
                consumeCount++;
                if (firstOutCycle < 0) firstOutCycle = cycleNo;
                lastOutCycle = cycleNo;
            end
            if (inValid && inReady) begin
                monExp.res = modelMul(inA, inB, inSigned);
                monExp.tag = inTag;
                expQ.push_back(monExp);
                acceptCount++;
                if (firstAcceptCycle < 0) firstAcceptCycle = cycleNo;
            end
            if (flush) expQ.delete();
            prevHeld   = outValid & ~outReady & ~flush;
            prevResult = outResult;
            prevTag    = outTag;
        end
    end

    task automatic newToken();
        curA      = $urandom;
        curB      = $urandom;
        if ($urandom_range(0, 3) == 0) curA = 32'h8000_0000;
        if ($urandom_range(0, 3) == 0) curB = 32'hFFFF_FFFF;
        curSigned = 1'($urandom_range(0, 1));
        curTag    = tagCounter;
        tagCounter++;
    endtask

    // One clock cycle: drive just after a rising edge, sample on the falling
    // edge, return just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic r, input logic f, output logic acc);
        inValid  = v;
        outReady = r;
        flush    = f;
        inA      = curA;
        inB      = curB;
        inSigned = curSigned;
        inTag    = curTag;
        @(negedge clk);
        smpReady  = inReady;
        smpValid  = outValid;
        smpResult = outResult;
        smpTag    = outTag;
        acc       = v & inReady;
        @(posedge clk);
        #1;
    endtask

    task automatic autoCycle(input logic v, input logic r, input logic f);
        logic acc;
        applyStimulus(v, r, f, acc);
        if (acc) newToken();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((expQ.size() != 0 || busy) && k < 60) begin
            autoCycle(1'b0, 1'b1, 1'b0);
            k++;
        end
        if (k >= 60) failNow({name, "Timeout"});
        checkOutput({name, "Empty"}, 64'(expQ.size()), 64'd0);
        checkOutput({name, "Busy"}, 64'(busy), 64'd0);
    endtask

    // Token presented in cycle c must show out_valid in cycle c+4
    task automatic measureLatency(input string name);
        logic acc;
        int   acceptCyc;
        firstOutCycle = -1;
        acceptCyc = cycleNo;
        applyStimulus(1'b1, 1'b1, 1'b0, acc);
        checkOutput({name, "Accept"}, 64'(acc), 64'd1);
        newToken();
        for (int k = 0; k < 20 && firstOutCycle < 0; k++) autoCycle(1'b0, 1'b1, 1'b0);
        if (firstOutCycle < 0) failNow(name);
        else checkOutput(name, 64'(firstOutCycle - acceptCyc), 64'd4);
    endtask

    initial begin
        logic acc;
        logic gotOut;
        int   acc0, cons0;
        logic allReady;

        vecs[0] = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 64'h0000_0000_8000_0000, "vecNegOneTimesMin"};
        vecs[1] = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 64'h7FFF_FFFF_8000_0000, "vecUnsMaxTimesMsb"};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "vecMinSquaredSig"};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "vecMinSquaredUns"};
        vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0001, "vecMaxTimesNegOne"};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 64'h0000_0000_0000_0000, "vecZero"};
        vecs[6] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 64'h0000_0000_0000_000F, "vecSmallUns"};
        vecs[7] = '{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "vecNegThreeTimesSeven"};
        vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "vecUnsMaxSquared"};
        vecs[9] = '{32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780, "vecShiftBy16"};

        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inA = '0; inB = '0; inSigned = 1'b0; inTag = '0;
        curA = '0; curB = '0; curSigned = 1'b0; curTag = '0;
        #1;
        checkOutput("resetOutValid", 64'(outValid), 64'd0);
        checkOutput("resetOutResult", outResult, 64'd0);
        checkOutput("resetOutTag", 64'(outTag), 64'd0);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetInReady", 64'(inReady), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < NV; i++) begin
            curA = vecs[i].a; curB = vecs[i].b; curSigned = vecs[i].s; curTag = TW'(i);
            applyStimulus(1'b1, 1'b1, 1'b0, acc);
            checkOutput("vecAccept", 64'(acc), 64'd1);
            gotOut = 1'b0;
            for (int k = 0; k < 20 && !gotOut; k++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, acc);
                if (smpValid) begin
                    gotOut = 1'b1;
                    checkOutput(vecs[i].name, smpResult, vecs[i].exp);
                    checkOutput("vecTag", 64'(smpTag), 64'(i));
                end
            end
            if (!gotOut) failNow(vecs[i].name);
        end
        drain("vecDrain");

        $display("[TB] streaming eight back-to-back tokens");
        tagCounter = '0;
        newToken();
        firstAcceptCycle = -1; firstOutCycle = -1;
        acc0 = acceptCount; cons0 = consumeCount;
        allReady = 1'b1;
        for (int c = 0; c < 8; c++) begin
            autoCycle(1'b1, 1'b1, 1'b0);
            allReady &= smpReady;
        end
        for (int c = 0; c < 10; c++) autoCycle(1'b0, 1'b1, 1'b0);
        checkOutput("streamInReady", 64'(allReady), 64'd1);
        checkOutput("streamAccepted", 64'(acceptCount - acc0), 64'd8);
        checkOutput("streamConsumed", 64'(consumeCount - cons0), 64'd8);
        checkOutput("streamLatency", 64'(firstOutCycle - firstAcceptCycle), 64'd4);
        checkOutput("streamBackToBack", 64'(lastOutCycle - firstOutCycle), 64'd7);
        drain("streamDrain");

        $display("[TB] backpressure");
        acc0 = acceptCount; cons0 = consumeCount;
        for (int c = 0; c < 10; c++) autoCycle(1'b1, 1'b0, 1'b0);
        checkOutput("bpAccepted", 64'(acceptCount - acc0), 64'd4);
        checkOutput("bpInReady", 64'(inReady), 64'd0);
        checkOutput("bpOutValid", 64'(outValid), 64'd1);
        for (int c = 0; c < 20; c++) autoCycle(1'b1, 1'(c % 2 == 0), 1'b0);
        drain("bpDrain");
        checkOutput("bpExactlyOnce", 64'(consumeCount - cons0), 64'(acceptCount - acc0));

        $display("[TB] bubble collapse");
        acc0 = acceptCount;
        for (int c = 0; c < 12; c++) autoCycle(1'(c % 2 == 0), 1'b0, 1'b0);
        checkOutput("bubbleAccepted", 64'(acceptCount - acc0), 64'd4);
        checkOutput("bubbleInReady", 64'(inReady), 64'd0);
        drain("bubbleDrain");

        $display("[TB] flush with three tokens in flight");
        cons0 = consumeCount;
        for (int c = 0; c < 3; c++) autoCycle(1'b1, 1'b1, 1'b0);
        autoCycle(1'b0, 1'b1, 1'b1);
        checkOutput("flushInReady", 64'(smpReady), 64'd0);
        flush = 1'b0;
        checkOutput("flushOutValid", 64'(outValid), 64'd0);
        checkOutput("flushBusy", 64'(busy), 64'd0);
        checkOutput("flushNoResults", 64'(consumeCount - cons0), 64'd0);
        measureLatency("flushLatency");
        drain("flushDrain");

        $display("[TB] flush while a result is being taken");
        cons0 = consumeCount;
        for (int c = 0; c < 4; c++) autoCycle(1'b1, 1'b1, 1'b0);
        autoCycle(1'b0, 1'b1, 1'b1);
        flush = 1'b0;
        checkOutput("flushTakeConsumed", 64'(consumeCount - cons0), 64'd1);
        checkOutput("flushTakeOutValid", 64'(outValid), 64'd0);
        checkOutput("flushTakeBusy", 64'(busy), 64'd0);
        drain("flushTakeDrain");

        $display("[TB] asynchronous reset mid-stream");
        for (int c = 0; c < 4; c++) autoCycle(1'b1, 1'b1, 1'b0);
        checkOutput("rstPreValid", 64'(outValid), 64'd1);
        inValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstOutValid", 64'(outValid), 64'd0);
        checkOutput("rstOutResult", outResult, 64'd0);
        checkOutput("rstOutTag", 64'(outTag), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        measureLatency("rstLatency");
        drain("rstDrain");

        $display("[TB] randomised valid/ready traffic");
        acc0 = acceptCount; cons0 = consumeCount;
        for (int c = 0; c < 400; c++)
            autoCycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 1'b0);
        drain("randDrain");
        checkOutput("randExactlyOnce", 64'(consumeCount - cons0), 64'(acceptCount - acc0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
